vsc_ram_dma: RTL and testbench

//   Block-copy/fill engine that masters the single-port block RAM exactly as VerySimpleCPU does:

---
 rtl/vsc_ram_dma_pkg.sv | 19 +
 rtl/vsc_ram_dma_if.sv | 30 +++
 rtl/vsc_ram_dma.sv | 148 ++++++++++++++
 tb/tb_vsc_ram_dma.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vsc_ram_dma_pkg.sv
// Shared constants for the RAM block-copy/fill engine.
// The state encodings and read latency are also used by the CPU side of the RAM port mux.
package vsc_ram_dma_pkg;

  // Engine states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_WR   = 2'd3;

  // Transfer modes
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  // Block RAM read latency in cycles: the address is sampled at one edge and the
  // data is visible after it.
  localparam int unsigned RAM_RD_LATENCY = 1;

endpackage

// File: rtl/vsc_ram_dma_if.sv
// Single-port block RAM bus as seen by VerySimpleCPU-style masters.
//   wrEn          master -> RAM  write enable
//   addr_toRAM    master -> RAM  word address
//   data_toRAM    master -> RAM  write data
//   data_fromRAM  RAM -> master  read data, valid the cycle after the address is sampled
interface vsc_ram_dma_if #(
  parameter int unsigned SIZE   = 14,
  parameter int unsigned DATA_W = 32
) ();

  logic              wrEn;
  logic [SIZE-1:0]   addr_toRAM;
  logic [DATA_W-1:0] data_toRAM;
  logic [DATA_W-1:0] data_fromRAM;

  modport master (
    output wrEn,
    output addr_toRAM,
    output data_toRAM,
    input  data_fromRAM
  );

  modport slave (
    input  wrEn,
    input  addr_toRAM,
    input  data_toRAM,
    output data_fromRAM
  );

endinterface

// File: rtl/vsc_ram_dma.sv
// Block-copy/fill engine that masters the single-port block RAM.
// Copy moves len words from src_addr to dst_addr in ascending order (3 cycles/word);
// fill writes pattern to len words from dst_addr (1 cycle/word). Addresses wrap modulo 2^SIZE.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   start         request, only sampled while idle
//   mode          0 = copy, 1 = fill
//   src_addr      first source word (copy)
//   dst_addr      first destination word
//   len           word count, 0..2^SIZE
//   pattern       fill value
//   busy          high while a transfer is in progress
//   done          one-cycle completion pulse
//   ram           RAM bus (master side), all outputs registered
module vsc_ram_dma
  import vsc_ram_dma_pkg::*;
#(
  parameter int unsigned SIZE   = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [SIZE-1:0]   src_addr,
  input  logic [SIZE-1:0]   dst_addr,
  input  logic [SIZE:0]     len,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  vsc_ram_dma_if.master     ram
);

  logic [1:0]        state_q, state_d;
  logic              mode_q, mode_d;
  logic [SIZE-1:0]   src_q, src_d;
  logic [SIZE-1:0]   dst_q, dst_d;
  logic [SIZE:0]     remain_q, remain_d;
  logic [SIZE-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    src_d    = src_q;
    dst_d    = dst_q;
    remain_d = remain_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = wr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            // Empty transfer: acknowledge without touching the RAM.
            done_d = 1'b1;
          end else begin
            mode_d   = mode;
            src_d    = src_addr;
            dst_d    = dst_addr;
            remain_d = len;
            busy_d   = 1'b1;
            if (mode == MODE_COPY) begin
              addr_d  = src_addr;
              state_d = ST_RD;
            end else begin
              addr_d  = dst_addr;
              data_d  = pattern;
              wr_d    = 1'b1;
              state_d = ST_WR;
            end
          end
        end
      end

      // RAM samples the source address at the end of this cycle.
      ST_RD: state_d = ST_WAIT;

      ST_WAIT: begin
        addr_d  = dst_q;
        data_d  = ram.data_fromRAM;
        wr_d    = 1'b1;
        state_d = ST_WR;
      end

      ST_WR: begin
        // The RAM commits the current word at the closing edge of this cycle.
        remain_d = remain_q - 1'b1;
        src_d    = src_q + 1'b1;
        dst_d    = dst_q + 1'b1;
        if (remain_q == (SIZE+1)'(1)) begin
          wr_d    = 1'b0;
          addr_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (mode_q == MODE_COPY) begin
          wr_d    = 1'b0;
          addr_d  = src_q + 1'b1;
          state_d = ST_RD;
        end else begin
          addr_d = dst_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_COPY;
      src_q    <= '0;
      dst_q    <= '0;
      remain_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      remain_q <= remain_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign ram.wrEn       = wr_q;
  assign ram.addr_toRAM = addr_q;
  assign ram.data_toRAM = data_q;

endmodule

// File: tb/tb_vsc_ram_dma.sv
// Self-checking bench for vsc_ram_dma with a 1024-word behavioural block RAM.
// A transaction-level model expands each accepted request into the expected per-cycle
// output sequence and the resulting memory image; a compare process checks every cycle.
module tb_vsc_ram_dma;
  import vsc_ram_dma_pkg::*;

  localparam int unsigned SIZE   = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              mode;
  logic [SIZE-1:0]   src_addr;
  logic [SIZE-1:0]   dst_addr;
  logic [SIZE:0]     len;
  logic [DATA_W-1:0] pattern;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  vsc_ram_dma_if #(.SIZE(SIZE), .DATA_W(DATA_W)) ram_if ();

  vsc_ram_dma #(.SIZE(SIZE), .DATA_W(DATA_W)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .pattern  (pattern),
    .busy     (busy),
    .done     (done),
    .ram      (ram_if)
  );

  // Block RAM with a backdoor port for preloading.
  logic [31:0]     mem [DEPTH];
  logic            bd_we = 1'b0;
  logic [SIZE-1:0] bd_addr = '0;
  logic [31:0]     bd_data = '0;

  always @(posedge clk) begin
    if (ram_if.wrEn) mem[ram_if.addr_toRAM] <= ram_if.data_toRAM;
    else if (bd_we)  mem[bd_addr] <= bd_data;
    ram_if.data_fromRAM <= mem[ram_if.addr_toRAM];
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic            busy;
    logic            done;
    logic            wr;
    logic [SIZE-1:0] addr;
    logic [31:0]     data;
  } outs_t;

  outs_t       exp_q[$];
  outs_t       cur;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] scratch [DEPTH];
  logic [SIZE-1:0] ms, mt;
  logic [31:0]     mv, md;
  int              mn;

  function automatic outs_t mk(input logic b, input logic dn, input logic w,
                               input logic [SIZE-1:0] a, input logic [31:0] d);
    outs_t o;
    o.busy = b; o.done = dn; o.wr = w; o.addr = a; o.data = d;
    return o;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      cur = '0;
    end else begin
      if (cur.wr) ref_mem[cur.addr] = cur.data;
      else if (bd_we) ref_mem[bd_addr] = bd_data;
      if (exp_q.size() == 0 && start) begin
        mn = int'(len);
        md = cur.data;
        if (mn == 0) begin
          exp_q.push_back(mk(1'b0, 1'b1, 1'b0, cur.addr, cur.data));
        end else if (mode == MODE_COPY) begin
          for (int a = 0; a < DEPTH; a++) scratch[a] = ref_mem[a];
          for (int i = 0; i < mn; i++) begin
            ms = SIZE'((int'(src_addr) + i) % DEPTH);
            mt = SIZE'((int'(dst_addr) + i) % DEPTH);
            mv = scratch[ms];
            scratch[mt] = mv;
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, ms, md));
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, ms, md));
            exp_q.push_back(mk(1'b1, 1'b0, 1'b1, mt, mv));
            md = mv;
          end
          exp_q.push_back(mk(1'b0, 1'b1, 1'b0, '0, md));
        end else begin
          for (int i = 0; i < mn; i++) begin
            mt = SIZE'((int'(dst_addr) + i) % DEPTH);
            exp_q.push_back(mk(1'b1, 1'b0, 1'b1, mt, pattern));
          end
          exp_q.push_back(mk(1'b0, 1'b1, 1'b0, '0, pattern));
        end
      end
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = mk(1'b0, 1'b0, 1'b0, cur.addr, cur.data);
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  int busy_total = 0;
  int done_total = 0;
  int wr_total = 0;

  initial begin : compare
    outs_t act;
    forever begin
      @(negedge clk);
      act = mk(busy, done, ram_if.wrEn, ram_if.addr_toRAM, ram_if.data_toRAM);
      checks++;
      if (act !== cur) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got busy=%b done=%b wr=%b addr=%0d data=%h exp busy=%b done=%b wr=%b addr=%0d data=%h",
                 $time, act.busy, act.done, act.wr, act.addr, act.data,
                 cur.busy, cur.done, cur.wr, cur.addr, cur.data);
      end
      if (busy) busy_total++;
      if (done) done_total++;
      if (ram_if.wrEn) wr_total++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic bd(input int a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = SIZE'(a); bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wait_idle got=timeout exp=done within %0d cycles", budget);
    end
    @(negedge clk);
  endtask

  task automatic run(input logic m, input int s, input int d, input int l, input logic [31:0] p);
    mode = m; src_addr = SIZE'(s); dst_addr = SIZE'(d); len = (SIZE+1)'(l); pattern = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(3 * l + 20);
  endtask

  int b0, d0, w0, l, extra;

  initial begin
    rst = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    len = '0; pattern = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_wren", 32'(ram_if.wrEn), 32'd0);
    chk("reset_addr", 32'(ram_if.addr_toRAM), 32'd0);
    chk("reset_data", ram_if.data_toRAM, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    for (int a = 0; a < DEPTH; a++) bd(a, $urandom);

    // Copy 4 words
    for (int i = 0; i < 4; i++) bd(100 + i, 32'(5 + i));
    bd(204, 32'h1234_5678);
    b0 = busy_total; d0 = done_total;
    run(MODE_COPY, 100, 200, 4, 32'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("copy_mem%0d", 200 + i), mem[200 + i], 32'(5 + i));
    chk("copy_mem204", mem[204], 32'h1234_5678);
    chk("copy_busy_cycles", 32'(busy_total - b0), 32'd12);
    chk("copy_done_pulses", 32'(done_total - d0), 32'd1);

    // Fill 3 words
    b0 = busy_total; w0 = wr_total;
    run(MODE_FILL, 0, 300, 3, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) chk($sformatf("fill_mem%0d", 300 + i), mem[300 + i], 32'hDEAD_BEEF);
    chk("fill_wr_cycles", 32'(wr_total - w0), 32'd3);
    chk("fill_busy_cycles", 32'(busy_total - b0), 32'd3);

    // Zero length
    b0 = busy_total; w0 = wr_total; d0 = done_total;
    mode = MODE_FILL; dst_addr = 10'd50; len = '0; pattern = 32'h5555_5555;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("len0_done_next", 32'(done), 32'd1);
    @(negedge clk);
    chk("len0_done_single", 32'(done), 32'd0);
    chk("len0_busy", 32'(busy_total - b0), 32'd0);
    chk("len0_wren", 32'(wr_total - w0), 32'd0);
    chk("len0_done_pulses", 32'(done_total - d0), 32'd1);

    // Address wrap
    run(MODE_FILL, 0, 1023, 2, 32'd9);
    chk("wrap_mem1023", mem[1023], 32'd9);
    chk("wrap_mem0", mem[0], 32'd9);

    // Abort with an ignored second start
    for (int i = 0; i < 8; i++) bd(500 + i, 32'(100 + i));
    for (int i = 0; i < 8; i++) bd(600 + i, 32'hAAAA_AAAA);
    d0 = done_total;
    mode = MODE_COPY; src_addr = 10'd500; dst_addr = 10'd600; len = 11'd8; pattern = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    mode = MODE_FILL; dst_addr = 10'd0; len = 11'd1; pattern = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wren", 32'(ram_if.wrEn), 32'd0);
    chk("abort_data", ram_if.data_toRAM, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_mem600", mem[600], 32'd100);
    chk("abort_mem601", mem[601], 32'd101);
    chk("abort_mem602", mem[602], 32'hAAAA_AAAA);
    chk("abort_mem0_untouched", 32'(mem[0] == 32'hFFFF_FFFF), 32'd0);
    chk("abort_no_done", 32'(done_total - d0), 32'd0);

    // Overlapping copy smears ascending
    bd(10, 32'd1); bd(11, 32'd2); bd(12, 32'd3);
    run(MODE_COPY, 10, 11, 2, 32'h0);
    chk("overlap_mem11", mem[11], 32'd1);
    chk("overlap_mem12", mem[12], 32'd1);

    // Randomized transfers, with ignored restarts and occasional aborts
    for (int it = 0; it < 60; it++) begin
      mode = 1'($urandom_range(0, 1));
      src_addr = SIZE'($urandom); dst_addr = SIZE'($urandom);
      l = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 200) : $urandom_range(0, 12);
      len = (SIZE+1)'(l); pattern = $urandom;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      extra = 0;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        mode = 1'($urandom_range(0, 1));
        src_addr = SIZE'($urandom); dst_addr = SIZE'($urandom);
        extra = $urandom_range(0, 12);
        len = (SIZE+1)'(extra); pattern = $urandom;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 6)) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
      end
      wait_idle(3 * (l + extra) + 30);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Whole-RAM fill and whole-RAM overlapping copy
    run(MODE_FILL, 0, 7, 1024, 32'hCAFE_0001);
    chk("full_fill_mem6", mem[6], 32'hCAFE_0001);
    chk("full_fill_mem7", mem[7], 32'hCAFE_0001);
    for (int i = 0; i < 4; i++) bd(i, 32'(i + 40));
    run(MODE_COPY, 0, 512, 1024, 32'h0);
    chk("full_copy_mem515", mem[515], 32'd43);
    chk("full_copy_mem3", mem[3], 32'd43);

    for (int a = 0; a < DEPTH; a++) chk($sformatf("final_mem%0d", a), mem[a], ref_mem[a]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
